// File: rtl/serial_bus_master.sv
// Byte-stream driven bus initiator: host command frames from the UART receive path become
// single read/write cycles on the uds/lds/rw/ack bus, with results returned as UART bytes.
module serial_bus_master #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [23:0] master_addr,
    output logic [15:0] master_write,
    input  logic [15:0] master_read,
    output logic        master_uds,
    output logic        master_lds,
    output logic        rw,
    input  logic        master_ack,
    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, A2, A1, A0, D1, D0, BUS, RESP} state_t;

    state_t          state, state_nx;
    logic            is_read, is_word;
    logic [7:0]      data_hi;
    logic [CW-1:0]   bus_cnt;
    logic [15:0]     resp_buf;
    logic [1:0]      resp_left;
    logic            wait_rise;
    logic            valid_op;
    logic            timeout_hit;

    assign valid_op = (rx_data == 8'h52) || (rx_data == 8'h57) ||
                      (rx_data == 8'h72) || (rx_data == 8'h77);

    // Counter holds the number of ack-less cycles already completed in BUS.
    assign timeout_hit = (TIMEOUT != 0) && !master_ack && (bus_cnt == CW'(TIMEOUT - 1));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rx_valid) state_nx = valid_op ? A2 : RESP;
            A2:   if (rx_valid) state_nx = A1;
            A1:   if (rx_valid) state_nx = A0;
            A0: begin
                if (rx_valid) begin
                    if (is_word && rx_data[0]) state_nx = RESP;
                    else if (is_read)          state_nx = BUS;
                    else if (is_word)          state_nx = D1;
                    else                       state_nx = D0;
                end
            end
            D1:   if (rx_valid) state_nx = D0;
            D0:   if (rx_valid) state_nx = BUS;
            BUS:  if (master_ack || timeout_hit) state_nx = RESP;
            RESP: if (tx_start && (resp_left == 2'd0)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data      <= '0;
            tx_start     <= 1'b0;
            master_addr  <= '0;
            master_write <= '0;
            master_uds   <= 1'b0;
            master_lds   <= 1'b0;
            rw           <= 1'b1;
            is_read      <= 1'b0;
            is_word      <= 1'b0;
            data_hi      <= '0;
            bus_cnt      <= '0;
            resp_buf     <= '0;
            resp_left    <= '0;
            wait_rise    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        is_read   <= (rx_data == 8'h52) || (rx_data == 8'h72);
                        is_word   <= (rx_data == 8'h52) || (rx_data == 8'h57);
                        resp_buf  <= {8'h3F, 8'h00};
                        resp_left <= 2'd1;
                        wait_rise <= 1'b0;
                    end
                end
                A2: if (rx_valid) master_addr[23:16] <= rx_data;
                A1: if (rx_valid) master_addr[15:8] <= rx_data;
                A0: begin
                    if (rx_valid) begin
                        master_addr[7:0] <= rx_data;
                        if (is_word && rx_data[0]) begin
                            resp_buf  <= {8'h21, 8'h00};
                            resp_left <= 2'd1;
                        end else if (is_read) begin
                            master_uds <= is_word || !rx_data[0];
                            master_lds <= is_word || rx_data[0];
                            rw         <= 1'b1;
                            bus_cnt    <= '0;
                        end
                    end
                end
                D1: if (rx_valid) data_hi <= rx_data;
                D0: begin
                    if (rx_valid) begin
                        master_write <= is_word ? {data_hi, rx_data} : {rx_data, rx_data};
                        master_uds   <= is_word || !master_addr[0];
                        master_lds   <= is_word || master_addr[0];
                        rw           <= 1'b0;
                        bus_cnt      <= '0;
                    end
                end
                BUS: begin
                    wait_rise <= 1'b0;
                    if (master_ack) begin
                        master_uds <= 1'b0;
                        master_lds <= 1'b0;
                        rw         <= 1'b1;
                        if (is_read && is_word)  resp_buf <= master_read;
                        else if (!is_read)       resp_buf <= {8'h4B, 8'h00};
                        else if (master_addr[0]) resp_buf <= {master_read[7:0], 8'h00};
                        else                     resp_buf <= {master_read[15:8], 8'h00};
                        resp_left <= (is_read && is_word) ? 2'd2 : 2'd1;
                    end else begin
                        bus_cnt <= bus_cnt + 1'b1;
                        if (timeout_hit) begin
                            master_uds <= 1'b0;
                            master_lds <= 1'b0;
                            rw         <= 1'b1;
                            resp_buf   <= {8'h54, 8'h00};
                            resp_left  <= 2'd1;
                        end
                    end
                end
                RESP: begin
                    // A second byte needs a full rise/fall of tx_busy from the first one.
                    if (wait_rise) begin
                        if (tx_busy) wait_rise <= 1'b0;
                    end else if (!tx_busy && !tx_start && (resp_left != 2'd0)) begin
                        tx_start  <= 1'b1;
                        tx_data   <= resp_buf[15:8];
                        resp_buf  <= {resp_buf[7:0], 8'h00};
                        resp_left <= resp_left - 2'd1;
                        wait_rise <= (resp_left == 2'd2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// Self-checking bench for serial_bus_master: directed frames plus randomized transactions
// checked against a frame-level reference model, with a bus slave and UART transmitter model.
module tb_serial_bus_master;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_busy_m;
    logic        tx_hold;
    logic [23:0] master_addr;
    logic [15:0] master_write;
    logic [15:0] master_read;
    logic        master_uds, master_lds, rw;
    logic        master_ack;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    serial_bus_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .master_addr(master_addr), .master_write(master_write), .master_read(master_read),
        .master_uds(master_uds), .master_lds(master_lds), .rw(rw),
        .master_ack(master_ack), .busy(busy)
    );

    always #5 clk = ~clk;
    assign tx_busy = tx_busy_m | tx_hold;

    // Transmitter model: busy rises a random while after each tx_start, holds, then falls.
    initial begin
        tx_busy_m = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1 tx_busy_m = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_busy_m = 1'b0;
            end
        end
    end

    logic [7:0] tx_q[$];
    logic       prev_start = 1'b0;
    int         consec = 0;
    int         overrun = 0;

    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (prev_start) consec <= consec + 1;
            if (tx_busy)    overrun <= overrun + 1;
        end
        prev_start <= tx_start;
    end

    // Observations from the last run_txn
    int          o_ncyc, o_txn;
    logic [31:0] o_txv;
    logic [23:0] o_addr;
    logic [15:0] o_write;
    logic        o_uds, o_lds, o_rw, o_unstable, o_hung;

    // Reference model expectations
    int          e_ncyc, e_txn;
    logic [31:0] e_txv;
    logic        e_bus, e_uds, e_lds, e_rw;
    logic [15:0] e_write;

    function automatic bit op_valid(input logic [7:0] op);
        return op == 8'h52 || op == 8'h57 || op == 8'h72 || op == 8'h77;
    endfunction

    task automatic model(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int ack_cycles);
        bit word, rd, tmo;
        word = (op == 8'h52) || (op == 8'h57);
        rd   = (op == 8'h52) || (op == 8'h72);
        e_bus = 0; e_ncyc = 0; e_txn = 1;
        e_uds = 0; e_lds = 0; e_rw = 1; e_write = 16'h0;
        if (!op_valid(op)) begin
            e_txv = 32'h3F;
        end else if (word && addr[0]) begin
            e_txv = 32'h21;
        end else begin
            e_bus   = 1;
            e_uds   = word || !addr[0];
            e_lds   = word || addr[0];
            e_rw    = rd;
            e_write = word ? wdata : {wdata[7:0], wdata[7:0]};
            tmo     = (ack_cycles == 0) || (ack_cycles > int'(TO));
            e_ncyc  = tmo ? int'(TO) : ack_cycles;
            if (tmo)            e_txv = 32'h54;
            else if (!rd)       e_txv = 32'h4B;
            else if (word)      begin e_txn = 2; e_txv = {16'h0, rdata}; end
            else if (addr[0])   e_txv = {24'h0, rdata[7:0]};
            else                e_txv = {24'h0, rdata[15:8]};
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int ack_cycles, input bit late_ack);
        logic [7:0] frame[$];
        bit done = 0;
        frame = {op};
        if (op_valid(op)) begin
            frame.push_back(addr[23:16]);
            frame.push_back(addr[15:8]);
            frame.push_back(addr[7:0]);
            if (op == 8'h57 && !addr[0]) begin
                frame.push_back(wdata[15:8]);
                frame.push_back(wdata[7:0]);
            end
            if (op == 8'h77) frame.push_back(wdata[7:0]);
        end
        tx_q.delete();
        master_read = rdata;
        master_ack  = 1'b0;
        o_ncyc = 0; o_unstable = 0; o_hung = 0;
        o_addr = '0; o_write = '0; o_uds = 0; o_lds = 0; o_rw = 1;
        foreach (frame[i]) send_byte(frame[i]);
        for (int c = 0; c < 300; c++) begin
            if (master_uds || master_lds) begin
                if (o_ncyc == 0) begin
                    o_addr = master_addr; o_write = master_write;
                    o_uds = master_uds; o_lds = master_lds; o_rw = rw;
                end else if (o_addr !== master_addr || o_write !== master_write ||
                             o_uds !== master_uds || o_lds !== master_lds || o_rw !== rw) begin
                    o_unstable = 1;
                end
                o_ncyc++;
                master_ack = (ack_cycles != 0) && (o_ncyc == ack_cycles);
            end else begin
                master_ack = late_ack && (o_ncyc != 0);
            end
            if (!busy) begin done = 1; break; end
            @(posedge clk); #1;
        end
        master_ack = 1'b0;
        if (!done) o_hung = 1;
        repeat (3) begin @(posedge clk); #1; end
        o_txn = tx_q.size();
        o_txv = '0;
        foreach (tx_q[i]) o_txv = {o_txv[23:0], tx_q[i]};
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_valid = 0; rx_data = 0; master_ack = 0; master_read = 0; tx_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({master_uds, master_lds, rw, master_addr, master_write, tx_data, tx_start, busy} !==
            {1'b0, 1'b0, 1'b1, 24'h0, 16'h0, 8'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: uds=%b lds=%b rw=%b addr=%h wr=%h txd=%h txs=%b busy=%b, want 0 0 1 0 0 0 0 0",
                     master_uds, master_lds, rw, master_addr, master_write, tx_data, tx_start, busy);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_read();
        run_txn(8'h52, 24'h001000, 16'h0, 16'hBEEF, 3, 0);
        vectors++;
        if ({o_addr, o_uds, o_lds, o_rw} !== {24'h001000, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL wrd_bus: addr=%h uds=%b lds=%b rw=%b, want 001000 1 1 1", o_addr, o_uds, o_lds, o_rw);
        end
        vectors++;
        if (o_ncyc !== 3) begin
            miscompares++; $display("FAIL wrd_ncyc: got %0d want 3", o_ncyc);
        end
        vectors++;
        if (o_txn !== 2 || o_txv !== 32'hBEEF) begin
            miscompares++; $display("FAIL wrd_tx: got %0d bytes %h want 2 bytes BEEF", o_txn, o_txv);
        end
    endtask

    task automatic test_word_write();
        run_txn(8'h57, 24'h002002, 16'h1234, 16'h0, 1, 0);
        vectors++;
        if ({o_write, o_rw, o_uds, o_lds} !== {16'h1234, 1'b0, 1'b1, 1'b1} || o_ncyc !== 1) begin
            miscompares++;
            $display("FAIL wwr_bus: write=%h rw=%b uds=%b lds=%b ncyc=%0d, want 1234 0 1 1 1",
                     o_write, o_rw, o_uds, o_lds, o_ncyc);
        end
        vectors++;
        if (o_txn !== 1 || o_txv !== 32'h4B) begin
            miscompares++; $display("FAIL wwr_tx: got %0d bytes %h want 1 byte 4B", o_txn, o_txv);
        end
    endtask

    task automatic test_byte_ops();
        run_txn(8'h77, 24'h003001, 16'h00A5, 16'h0, 1, 0);
        vectors++;
        if ({o_uds, o_lds, o_write, o_rw} !== {1'b0, 1'b1, 16'hA5A5, 1'b0} || o_txv !== 32'h4B) begin
            miscompares++;
            $display("FAIL bwr: uds=%b lds=%b write=%h rw=%b tx=%h, want 0 1 A5A5 0 4B",
                     o_uds, o_lds, o_write, o_rw, o_txv);
        end
        run_txn(8'h72, 24'h003000, 16'h0, 16'h5A00, 2, 0);
        vectors++;
        if ({o_uds, o_lds, o_rw} !== 3'b101 || o_txn !== 1 || o_txv !== 32'h5A) begin
            miscompares++;
            $display("FAIL brd: uds=%b lds=%b rw=%b txn=%0d tx=%h, want 1 0 1 1 5A",
                     o_uds, o_lds, o_rw, o_txn, o_txv);
        end
    endtask

    task automatic test_errors();
        run_txn(8'h57, 24'h000001, 16'h0, 16'h0, 1, 0);
        vectors++;
        if (o_ncyc !== 0 || o_txn !== 1 || o_txv !== 32'h21 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL odd_word: ncyc=%0d txn=%0d tx=%h busy=%b, want 0 1 21 0", o_ncyc, o_txn, o_txv, busy);
        end
        run_txn(8'h00, 24'h0, 16'h0, 16'h0, 1, 0);
        vectors++;
        if (o_ncyc !== 0 || o_txn !== 1 || o_txv !== 32'h3F || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_op: ncyc=%0d txn=%0d tx=%h busy=%b, want 0 1 3F 0", o_ncyc, o_txn, o_txv, busy);
        end
    endtask

    task automatic test_timeout();
        run_txn(8'h52, 24'h000000, 16'h0, 16'hFFFF, 0, 1);
        vectors++;
        if (o_ncyc !== 8 || o_txn !== 1 || o_txv !== 32'h54) begin
            miscompares++;
            $display("FAIL timeout: ncyc=%0d txn=%0d tx=%h, want 8 1 54", o_ncyc, o_txn, o_txv);
        end
        run_txn(8'h52, 24'h000000, 16'h0, 16'h1357, 8, 0);
        vectors++;
        if (o_ncyc !== 8 || o_txn !== 2 || o_txv !== 32'h1357) begin
            miscompares++;
            $display("FAIL ack_at_timeout: ncyc=%0d txn=%0d tx=%h, want 8 2 1357", o_ncyc, o_txn, o_txv);
        end
    endtask

    task automatic test_reset_mid();
        master_ack = 1'b0;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        @(posedge clk); #1;
        vectors++;
        if (!(master_uds && master_lds)) begin
            miscompares++; $display("FAIL mid_bus_pre: uds=%b lds=%b want 1 1", master_uds, master_lds);
        end
        do_reset();
        vectors++;
        if ({master_uds, master_lds, rw, master_addr, tx_start, busy} !== {1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_bus_rst: uds=%b lds=%b rw=%b addr=%h txs=%b busy=%b, want 0 0 1 0 0 0",
                     master_uds, master_lds, rw, master_addr, tx_start, busy);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        tx_hold = 1'b1;
        master_ack = 1'b1;
        send_byte(8'h77); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01); send_byte(8'hA5);
        master_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (busy !== 1'b1 || tx_start !== 1'b0 || master_write !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL txbusy_hold: busy=%b txs=%b write=%h, want 1 0 A5A5", busy, tx_start, master_write);
        end
        do_reset();
        vectors++;
        if ({master_write, master_addr, tx_data, busy, rw} !== {16'h0, 24'h0, 8'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL txbusy_rst: write=%h addr=%h txd=%h busy=%b rw=%b, want 0 0 0 0 1",
                     master_write, master_addr, tx_data, busy, rw);
        end
        @(negedge clk) reset_n = 1'b1;
        tx_hold = 1'b0;
        @(posedge clk); #1;
        run_txn(8'h52, 24'h001000, 16'h0, 16'hBEEF, 3, 0);
        vectors++;
        if (o_ncyc !== 3 || o_txn !== 2 || o_txv !== 32'hBEEF) begin
            miscompares++;
            $display("FAIL post_reset_read: ncyc=%0d txn=%0d tx=%h, want 3 2 BEEF", o_ncyc, o_txn, o_txv);
        end
    endtask

    task automatic test_random();
        logic [7:0]  ops[4] = '{8'h52, 8'h57, 8'h72, 8'h77};
        logic [7:0]  op;
        logic [23:0] addr;
        logic [15:0] wd, rd;
        int          ackc;
        bit          late;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                op = 8'($urandom);
                while (op_valid(op)) op = 8'($urandom);
            end else begin
                op = ops[$urandom_range(0, 3)];
            end
            addr = 24'($urandom);
            wd   = 16'($urandom);
            rd   = 16'($urandom);
            ackc = $urandom_range(0, 10);
            late = 1'($urandom);
            model(op, addr, wd, rd, ackc);
            run_txn(op, addr, wd, rd, ackc, late);
            vectors++;
            if (o_txn !== e_txn || o_txv !== e_txv || o_hung) begin
                miscompares++;
                $display("FAIL rnd%0d_tx: op=%h addr=%h ack=%0d got %0d bytes %h hung=%b want %0d bytes %h",
                         n, op, addr, ackc, o_txn, o_txv, o_hung, e_txn, e_txv);
            end
            vectors++;
            if (o_ncyc !== e_ncyc) begin
                miscompares++;
                $display("FAIL rnd%0d_ncyc: op=%h addr=%h ack=%0d got %0d want %0d", n, op, addr, ackc, o_ncyc, e_ncyc);
            end
            if (e_bus) begin
                vectors++;
                if ({o_addr, o_uds, o_lds, o_rw, o_unstable} !== {addr, e_uds, e_lds, e_rw, 1'b0} ||
                    (!e_rw && o_write !== e_write)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_bus: addr=%h uds=%b lds=%b rw=%b wr=%h unst=%b want %h %b %b %b %h 0",
                             n, o_addr, o_uds, o_lds, o_rw, o_write, o_unstable,
                             addr, e_uds, e_lds, e_rw, e_write);
                end
            end
            vectors++;
            if ({master_uds, master_lds, rw, busy} !== 4'b0010) begin
                miscompares++;
                $display("FAIL rnd%0d_idle: uds=%b lds=%b rw=%b busy=%b want 0 0 1 0",
                         n, master_uds, master_lds, rw, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_word_write();
        test_byte_ops();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        vectors++;
        if (consec !== 0 || overrun !== 0) begin
            miscompares++;
            $display("FAIL tx_protocol: back-to-back starts=%0d starts while busy=%0d, want 0 0", consec, overrun);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_bus_master.md
# serial_bus_master

Byte-stream-driven bus initiator. It turns host command bytes from the UART receive path into single read or write cycles on the 16-bit uds/lds/rw/ack slave bus, and returns the results as bytes on the UART transmit path. It sits in the system beside the CPU as a second master in front of the device mux, for debug and bootloader access to memory and peripherals; bus arbitration is outside this block.

## Interface
- TIMEOUT, 1024: cycles to wait for ack before abort; 0 = wait forever
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle strobe, send tx_data
- tx_busy  in  1  transmitter active; no tx_start while high
- master_addr  out  24  bus byte address
- master_write  out  16  write data
- master_read  in  16  read data
- master_uds  out  1  active-high upper strobe, data[15:8], even byte
- master_lds  out  1  active-high lower strobe, data[7:0], odd byte
- rw  out  1  1 = read, 0 = write
- master_ack  in  1  slave acknowledge, ends cycle
- busy  out  1  high from opcode accept until the last response byte is issued

## Operation
- Opcodes:
  - 0x52 'R': word read
  - 0x57 'W': word write
  - 0x72 'r': byte read
  - 0x77 'w': byte write
- Any other opcode gets reply 0x3F '?' and a return to IDLE.
- Frame layout: opcode, addr[23:16], addr[15:8], addr[7:0].
  - Word write appends data[15:8], data[7:0].
  - Byte write appends one data byte.
- States: IDLE → A2 → A1 → A0 → (D1 → D0 | D0 | none) → BUS → RESP → IDLE.
  - Each collection state advances only on rx_valid.
  - rx_valid in BUS or RESP is dropped.
- Strobes:
  - Word access asserts both uds and lds.
  - Word access with addr[0]=1 skips BUS and replies 0x21 '!'.
  - Byte access: addr[0]=0 asserts uds; addr[0]=1 asserts lds.
  - Byte write drives the data byte on both lanes.
- Responses, issued in RESP:
  - Word read: read[15:8], then read[7:0].
  - Byte read: the selected lane.
  - Write: 0x4B 'K'.
  - Timeout: 0x54 'T'.
- Each response byte goes out with tx_start on the first cycle with tx_busy low. The next byte waits for tx_busy to rise and then fall.
- In BUS, a cycle counter increments every cycle without ack. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT, strobes drop and the reply is 'T'.

## Timing
- Reset values:
  - master_uds/lds = 0, rw = 1, master_addr = 0, master_write = 0
  - tx_data = 0, tx_start = 0, busy = 0, state = IDLE
- Reset mid-operation aborts immediately; strobes fall asynchronously.
- Bus cycle timing:
  - Entry to BUS is the clock edge after the final frame byte's rx_valid.
  - addr, data, rw and strobes are registered and stable for the whole cycle.
  - Strobes are high from the first BUS cycle.
  - master_read is sampled on the edge where master_ack = 1.
  - Strobes fall on that same edge, so they are low the next cycle. rw returns to 1.
  - Minimum bus cycle is 1 clock when ack is already high.
- master_ack outside BUS is ignored.
- If ack and timeout occur in the same cycle, ack wins.
- First tx_start comes no earlier than 1 cycle after BUS exits.
- tx_start is never high on consecutive cycles.
- busy drops on the cycle after the last tx_start.
- No inter-byte timeout: a partial frame waits indefinitely.

## Test plan
- Word read: bytes 52 00 10 00, slave acks after 3 cycles with 0xBEEF.
  - addr = 0x001000, uds = lds = 1, rw = 1 for 3 cycles.
  - tx bytes BE, EF.
- Word write: bytes 57 00 20 02 12 34, immediate ack.
  - master_write = 0x1234, rw = 0, both strobes for 1 cycle.
  - tx 4B.
- Byte write and byte read:
  - 77 00 30 01 A5 gives lds only, write = 0xA5A5, tx 4B.
  - 72 00 30 00 with read = 0x5A00 gives uds only, tx 5A.
- Errors:
  - 57 00 00 01 gives no strobes, tx 21.
  - Opcode 0x00 gives tx 3F.
  - Both leave busy = 0 afterwards.
- Timeout with TIMEOUT = 8, 52 00 00 00, no ack.
  - Strobes high exactly 8 cycles, then tx 54.
  - An ack arriving later is ignored.
- Reset asserted during BUS or with tx_busy high.
  - All outputs take reset values at once.
  - A subsequent 52 00 10 00 completes normally.
